// File: rtl/trig_chk_array.sv
// Multi-channel trigger-property checker: start ##0 end[->1] |=> form,
// with check delay, per-channel timeout, disable and saturating fail counts.
module trig_chk_array #(
  parameter int NCH   = 4,
  parameter int DELAY = 1,
  parameter int TMO_W = 8,
  parameter int ERR_W = 8
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic               dis,
  input  logic               clr,
  input  logic [NCH-1:0]     start,
  input  logic [NCH-1:0]     end_evt,
  input  logic [NCH-1:0]     form,
  input  logic [TMO_W-1:0]   tmo_limit,
  output logic [NCH-1:0]     busy,
  output logic [NCH-1:0]     pass_p,
  output logic [NCH-1:0]     fail_p,
  output logic [NCH-1:0]     tmo_p,
  output logic [NCH*ERR_W-1:0] fail_cnt,
  output logic               any_fail
);

  localparam int DW = $clog2(DELAY + 1);
  localparam logic [DW-1:0]    DLY0 = DW'(DELAY - 1);
  localparam logic [TMO_W-1:0] WMAX = '1;
  localparam logic [ERR_W-1:0] EMAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT, CHK} st_t;

  logic [NCH-1:0] stk_d;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    st_t              st, st_n;
    logic [TMO_W-1:0] wcnt, wcnt_n, winc;
    logic [DW-1:0]    dly, dly_n;
    logic [ERR_W-1:0] cnt, cnt_n;
    logic             stk;
    logic             pass_n, fail_n, tmo_n;
    logic             busy_q, pass_q, fail_q, tmo_q;

    assign winc = wcnt + 1'b1;

    always_comb begin
      st_n   = st;
      wcnt_n = wcnt;
      dly_n  = dly;
      pass_n = 1'b0;
      fail_n = 1'b0;
      tmo_n  = 1'b0;
      if (dis) begin
        st_n = IDLE;
      end else begin
        unique case (st)
          IDLE: begin
            if (start[i]) begin
              if (end_evt[i]) begin
                st_n  = CHK;
                dly_n = DLY0;
              end else begin
                st_n   = WAIT;
                wcnt_n = '0;
              end
            end
          end
          WAIT: begin
            if (end_evt[i]) begin
              st_n  = CHK;
              dly_n = DLY0;
            end else if (tmo_limit != '0 && winc == tmo_limit) begin
              tmo_n = 1'b1;
              st_n  = IDLE;
            end else if (wcnt != WMAX) begin
              wcnt_n = winc;
            end
          end
          CHK: begin
            if (dly != '0) begin
              dly_n = dly - 1'b1;
            end else begin
              pass_n = form[i];
              fail_n = !form[i];
              st_n   = IDLE;
              // same-cycle start re-arms without a bubble
              if (start[i]) begin
                if (end_evt[i]) begin
                  st_n  = CHK;
                  dly_n = DLY0;
                end else begin
                  st_n   = WAIT;
                  wcnt_n = '0;
                end
              end
            end
          end
          default: st_n = IDLE;
        endcase
      end
    end

    always_comb begin
      cnt_n = cnt;
      if (clr)
        cnt_n = '0;
      else if (fail_n && cnt != EMAX)
        cnt_n = cnt + 1'b1;
    end

    assign stk_d[i] = clr ? 1'b0 : (stk | fail_n | tmo_n);

    always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
        st     <= IDLE;
        wcnt   <= '0;
        dly    <= '0;
        cnt    <= '0;
        stk    <= 1'b0;
        busy_q <= 1'b0;
        pass_q <= 1'b0;
        fail_q <= 1'b0;
        tmo_q  <= 1'b0;
      end else begin
        st     <= st_n;
        wcnt   <= wcnt_n;
        dly    <= dly_n;
        cnt    <= cnt_n;
        stk    <= stk_d[i];
        busy_q <= (st_n != IDLE);
        pass_q <= pass_n;
        fail_q <= fail_n;
        tmo_q  <= tmo_n;
      end
    end

    assign busy[i]   = busy_q;
    assign pass_p[i] = pass_q;
    assign fail_p[i] = fail_q;
    assign tmo_p[i]  = tmo_q;
    assign fail_cnt[i*ERR_W +: ERR_W] = cnt;
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst)
      any_fail <= 1'b0;
    else
      any_fail <= |stk_d;
  end

endmodule
